// File: rtl/instruction_fetch_if.sv
//------------------------------------------------------------------------------
// instruction_fetch_if : fetch-stage bundle (imem request, redirect, IF/ID handoff)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instruction_fetch_if #(
  parameter int Width = 32
);
  logic [Width-1:0] imem_address;
  logic             imem_valid;
  logic [Width-1:0] imem_data;
  logic             redirect_valid;
  logic [Width-1:0] redirect_target;
  logic [Width-1:0] instr;
  logic [Width-1:0] instr_pc;
  logic             instr_valid;
  logic             instr_ready;

  modport master (
    output imem_address, imem_valid, instr, instr_pc, instr_valid,
    input  imem_data, redirect_valid, redirect_target, instr_ready
  );

  modport slave (
    input  imem_address, imem_valid, instr, instr_pc, instr_valid,
    output imem_data, redirect_valid, redirect_target, instr_ready
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// instruction_fetch : PC owner, imem requester and IF/ID output register
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch #(
  parameter int               Width       = 32,
  parameter logic [Width-1:0] ResetVector = '0
) (
  input  wire logic            clk,
  input  wire logic            rst,
  instruction_fetch_if.master  bus
);

  localparam logic [Width-1:0] c_inc        = Width'(Width / 8);
  localparam logic [Width-1:0] c_align_mask = ~(c_inc - Width'(1));

  logic [Width-1:0] r_pc;
  logic [Width-1:0] r_instr;
  logic [Width-1:0] r_instr_pc;
  logic             r_instr_valid;
  logic             w_load;

  // A redirect suppresses the fetch so the stale PC never reaches decode.
  assign w_load = !rst && !bus.redirect_valid && (!r_instr_valid || bus.instr_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= ResetVector;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc          <= bus.redirect_target & c_align_mask;
      r_instr_valid <= 1'b0;
    end else if (w_load) begin
      r_instr       <= bus.imem_data;
      r_instr_pc    <= r_pc;
      r_instr_valid <= 1'b1;
      r_pc          <= r_pc + c_inc;
    end
  end

  assign bus.imem_address = r_pc;
  assign bus.imem_valid   = w_load;
  assign bus.instr        = r_instr;
  assign bus.instr_pc     = r_instr_pc;
  assign bus.instr_valid  = r_instr_valid;

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch-stage initiator for the instruction memory. It owns the program counter and drives the memory's `address`/`valid` request pair, then captures the combinationally returned word into an output register with its PC. It hands instructions to decode over a valid/ready handshake, and supports back-pressure stalls and branch/jump redirects. It sits between the core's control path (redirect source) and the instruction memory, feeding the IF/ID boundary.

## Interface
Parameters:
- `Width`, 32, address/data width; PC increment is `Width/8` bytes (4 at default)
- `ResetVector`, 0, PC value loaded on reset

Ports:
- `clk` in 1: clock, all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `imem_address` out Width: fetch address, equals `pc`
- `imem_valid` out 1: fetch request strobe to memory
- `imem_data` in Width: instruction word, combinationally returned for `imem_address`
- `redirect_valid` in 1: PC redirect request (taken branch/jump)
- `redirect_target` in Width: new PC; low `$clog2(Width/8)` bits forced to 0
- `instr` out Width: captured instruction
- `instr_pc` out Width: address `instr` was fetched from
- `instr_valid` out 1: `instr`/`instr_pc` hold a valid instruction
- `instr_ready` in 1: decode accepts `instr` this cycle

## Operation
- State: `pc` register, output register {`instr`, `instr_pc`, `instr_valid`}.
- `imem_address = pc` (combinational).
- `imem_valid = !rst && !redirect_valid && (!instr_valid || instr_ready)` (combinational). A fetch ("load") occurs in every cycle where `imem_valid` is 1.
- Load: `instr <= imem_data`, `instr_pc <= pc`, `instr_valid <= 1`, `pc <= pc + Width/8`. The addition wraps modulo 2^Width, so all-ones aligned PC → 0.
- Stall (`instr_valid && !instr_ready`, no redirect): `pc`, `instr`, `instr_pc`, `instr_valid` all hold; `imem_valid` = 0.
- Redirect (`redirect_valid` = 1): highest priority after reset.
  - `pc <= redirect_target` with alignment bits cleared.
  - `instr_valid <= 0` (flush); `instr`/`instr_pc` contents don't care.
  - No fetch that cycle, regardless of `instr_ready`.
  - If `instr_valid && instr_ready` in the same cycle, that handshake still completes. Discarding it is decode's responsibility.
- Consecutive redirects: the last one wins. The first fetch occurs in the first cycle with `redirect_valid` = 0.
- Accept-only cycle (`instr_valid && instr_ready` without load) arises only with redirect and is covered above.
- Priority: `rst` > `redirect_valid` > stall > load.

## Timing
- Reset values (cycle after `rst` sampled high): `pc = ResetVector`, `instr_valid = 0`, `instr = 0`, `instr_pc = 0`.
  - `imem_valid` is 0 while `rst` = 1.
  - `imem_address` = `ResetVector` from the first cycle after reset.
- Reset mid-stream discards any held instruction and pending redirect.
- Latency: the word at address A appears on `instr` one cycle after the cycle in which `imem_address = A` and `imem_valid = 1`.
- First post-reset cycle: `imem_valid = 1`, `imem_address = ResetVector`. Next cycle: `instr_valid = 1`, `instr_pc = ResetVector`.
- Throughput: with `instr_ready` held 1, one instruction per cycle, `instr_pc` advancing by `Width/8` each cycle.
- Redirect penalty: redirect in cycle N → `imem_address = target` in N+1 → `instr_valid` = 1 with `instr_pc = target` in N+2. `instr_valid` = 0 in N+1.
- Stall release: `instr_ready` rising in cycle N completes the handshake in N; the next instruction appears in N+1. No bubble, no duplicate, no skip.
- `instr_valid` never drops without a handshake except on redirect or reset.

## Test plan
- Reset/stream: memory word i = 0x1000_0000+i, `ResetVector` = 0, `instr_ready` = 1 → after reset, `instr`/`instr_pc` = (0x1000_0000,0x0), (0x1000_0001,0x4), (0x1000_0002,0x8) on consecutive cycles; `instr_valid` 0 for the first post-reset cycle only.
- Stall: drop `instr_ready` for 3 cycles while `instr_pc` = 0x8 → `instr` stays 0x1000_0002, `imem_valid` = 0, `pc` stays 0xC. After release, the next `instr_pc` = 0xC; no gaps or duplicates.
- Redirect: `redirect_valid` = 1, target 0x43, while streaming at 0x10 → next cycle `instr_valid` = 0 and `imem_address` = 0x40. The cycle after that, `instr_pc` = 0x40 and `instr` = 0x1000_0010.
- Redirect during stall: `instr_valid` = 1, `instr_ready` = 0, redirect to 0x20 → instruction flushed, then `instr_pc` = 0x20. The held instruction is never handshaken.
- Back-to-back redirects to 0x100 then 0x200 → no fetch from 0x100; the first valid `instr_pc` = 0x200.
- Reset mid-stream (`instr_valid` = 1, `pc` = 0x30) → the next cycle's outputs match the reset values, and streaming restarts at `ResetVector`. Also set `pc` = 0xFFFF_FFFC with ready → the following `instr_pc` = 0x0 (wrap).
